// File: rtl/ripple_sub_adder.sv
// N-bit ripple-carry adder/subtractor with registered result and status flags.
// D=0 computes B+A, D=1 computes B-A as B + ~A + 1; all outputs load every cycle.
module ripple_sub_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         D,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V,
    output logic         Z
);

    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

    logic [N-1:0] a_cond;
    logic [N:0]   carry;
    logic [N-1:0] s_d;
    logic         cout_d;
    logic         v_d;
    logic         z_d;

    logic [N-1:0] s_q;
    logic         cout_q;
    logic         v_q;
    logic         z_q;

    // Inverting A and injecting D as the LSB carry turns the adder into B - A.
    assign a_cond   = A ^ {N{D}};
    assign carry[0] = D;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign s_d[i]     = fa_sum(a_cond[i], B[i], carry[i]);
        assign carry[i+1] = fa_carry(a_cond[i], B[i], carry[i]);
    end

    assign cout_d = carry[N];
    assign v_d    = carry[N-1] ^ carry[N];
    assign z_d    = (s_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b1;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            v_q    <= v_d;
            z_q    <= z_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_ripple_sub_adder.sv
// Scoreboard bench for ripple_sub_adder at N=4, 8 and 32 sharing one stimulus stream.
module tb_ripple_sub_adder;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic [3:0] a;
        logic       d;
        logic [3:0] s;
        logic       c;
        logic       v;
        logic       z;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        d_in;

    logic [3:0]  s4;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic        c4, v4, z4, c8, v8, z8, c32, v32, z32;

    exp_t q4[$];
    exp_t q8[$];
    exp_t q32[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ripple_sub_adder #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .A(a_in[3:0]), .B(b_in[3:0]), .D(d_in),
        .S(s4), .Cout(c4), .V(v4), .Z(z4)
    );

    ripple_sub_adder #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .A(a_in[7:0]), .B(b_in[7:0]), .D(d_in),
        .S(s8), .Cout(c8), .V(v8), .Z(z8)
    );

    ripple_sub_adder #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .A(a_in), .B(b_in), .D(d_in),
        .S(s32), .Cout(c32), .V(v32), .Z(z32)
    );

    // Reference: plain integer add/subtract, signed range check for overflow.
    function automatic exp_t model(input int n, input logic r, input logic [31:0] a,
                                   input logic [31:0] b, input logic d);
        exp_t   e;
        longint mask, ua, ub, full, sa, sb, sr, smax, smin;
        if (r) begin
            e.s = '0; e.c = 1'b0; e.v = 1'b0; e.z = 1'b1;
            return e;
        end
        mask = (longint'(1) << n) - 1;
        ua   = longint'({32'b0, a}) & mask;
        ub   = longint'({32'b0, b}) & mask;
        full = d ? (ub + ((~ua) & mask) + 1) : (ub + ua);
        smax = (longint'(1) << (n - 1)) - 1;
        smin = -(longint'(1) << (n - 1));
        sa   = (ua > smax) ? ua - (longint'(1) << n) : ua;
        sb   = (ub > smax) ? ub - (longint'(1) << n) : ub;
        sr   = d ? (sb - sa) : (sb + sa);
        e.s  = 32'(full & mask);
        e.c  = ((full >> n) & 1) != 0;
        e.v  = (sr > smax) || (sr < smin);
        e.z  = (full & mask) == 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] s, input logic c,
                         input logic v, input logic z, input exp_t e);
        vectors++;
        if (s !== e.s || c !== e.c || v !== e.v || z !== e.z) begin
            miscompares++;
            $display("FAIL %s: got S=%h Cout=%b V=%b Z=%b, want S=%h Cout=%b V=%b Z=%b",
                     name, s, c, v, z, e.s, e.c, e.v, e.z);
        end
    endtask

    // Monitor: one registered result per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q4.size() > 0)  check("n4",  {28'b0, s4}, c4, v4, z4, q4.pop_front());
        if (q8.size() > 0)  check("n8",  {24'b0, s8}, c8, v8, z8, q8.pop_front());
        if (q32.size() > 0) check("n32", s32, c32, v32, z32, q32.pop_front());
    end

    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic d, input bit use_dir, input exp_t e4);
        rst  = r;
        a_in = a;
        b_in = b;
        d_in = d;
        @(posedge clk);
        q4.push_back(use_dir ? e4 : model(4, r, a, b, d));
        q8.push_back(model(8, r, a, b, d));
        q32.push_back(model(32, r, a, b, d));
        #1;
    endtask

    dir_t dir[15];
    exp_t e4;

    initial begin
        // r, B, A, D, S, Cout, V, Z for N=4
        dir[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        dir[1]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0};
        dir[2]  = '{1'b0, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0};
        dir[3]  = '{1'b0, 4'h0, 4'h1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0};
        dir[4]  = '{1'b0, 4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0};
        dir[5]  = '{1'b0, 4'h0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
        dir[6]  = '{1'b0, 4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
        dir[7]  = '{1'b0, 4'h2, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0};
        dir[8]  = '{1'b0, 4'h2, 4'hA, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0};
        dir[9]  = '{1'b0, 4'h7, 4'hF, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};
        dir[10] = '{1'b0, 4'hF, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        dir[11] = '{1'b0, 4'h0, 4'hF, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0};
        dir[12] = '{1'b0, 4'h1, 4'h1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
        dir[13] = '{1'b0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
        dir[14] = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; a_in = '0; b_in = '0; d_in = 1'b0;

        foreach (dir[i]) begin
            e4 = '{{28'b0, dir[i].s}, dir[i].c, dir[i].v, dir[i].z};
            apply(dir[i].r, {28'b0, dir[i].a}, {28'b0, dir[i].b}, dir[i].d, 1'b1, e4);
        end

        // Back-to-back random traffic, D alternating, with a reset pulse mid-stream.
        for (int k = 0; k < 1200; k++) begin
            apply((k == 600) || (k == 601), $urandom, $urandom, k[0], 1'b0, e4);
        end

        @(negedge clk);
        #1;
        vectors++;
        if (q4.size() + q8.size() + q32.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results still pending, want 0",
                     q4.size() + q8.size() + q32.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
